pc_stack: RTL and testbench

//  Parametrised program counter for the RISC core, with a hardware return-address stack.

---
 rtl/pc_stack.sv | 107 ++++++++++
 tb/tb_pc_stack.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with hardware return-address stack
// One next-PC action per cycle, chosen by fixed strobe priority; all outputs registered.
module pc_stack #(
    parameter int Psize = 6,
    parameter int Ssize = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCstall,
    input  logic             PCincr,
    input  logic             PCabsbranch,
    input  logic             PCrelbranch,
    input  logic             PCcall,
    input  logic             PCreturn,
    input  logic [Psize-1:0] Branchaddr,
    output logic [Psize-1:0] PCout,
    output logic             StackFull,
    output logic             StackEmpty,
    output logic             StackErr
);

    localparam int SPW = $clog2(Ssize + 1);
    localparam int IW  = (Ssize > 1) ? $clog2(Ssize) : 1;
    localparam logic [SPW-1:0] SP_MAX = SPW'(Ssize);

    logic [Psize-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic             r_full;
    logic             r_empty;
    logic             r_err;
    logic [Psize-1:0] r_stack [Ssize];

    logic [Psize-1:0] w_pc_next;
    logic [Psize-1:0] w_pc_plus1;
    logic [SPW-1:0]   w_sp_next;
    logic [SPW-1:0]   w_sp_dec;
    logic [IW-1:0]    w_push_idx;
    logic [IW-1:0]    w_pop_idx;
    logic             w_push;
    logic             w_err_set;

    assign w_pc_plus1 = r_pc + Psize'(1);
    assign w_sp_dec   = r_sp - SPW'(1);
    assign w_push_idx = r_sp[IW-1:0];
    assign w_pop_idx  = w_sp_dec[IW-1:0];

    always_comb begin
        w_pc_next = r_pc;
        w_sp_next = r_sp;
        w_push    = 1'b0;
        w_err_set = 1'b0;
        if (PCstall) begin
            w_pc_next = r_pc;
        end else if (PCreturn) begin
            if (r_empty) begin
                w_err_set = 1'b1;
            end else begin
                w_pc_next = r_stack[w_pop_idx];
                w_sp_next = w_sp_dec;
            end
        end else if (PCcall) begin
            if (r_full) begin
                w_err_set = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_pc_next = Branchaddr;
                w_sp_next = r_sp + SPW'(1);
            end
        end else if (PCabsbranch) begin
            w_pc_next = Branchaddr;
        end else if (PCrelbranch) begin
            // Two's-complement offset: a plain modular add gives the signed result.
            w_pc_next = r_pc + Branchaddr;
        end else if (PCincr) begin
            w_pc_next = w_pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_sp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_sp    <= w_sp_next;
            r_full  <= (w_sp_next == SP_MAX);
            r_empty <= (w_sp_next == '0);
            r_err   <= r_err | w_err_set;
        end
    end

    // Stack storage carries no reset; sp alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_plus1;
        end
    end

    assign PCout      = r_pc;
    assign StackFull  = r_full;
    assign StackEmpty = r_empty;
    assign StackErr   = r_err;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - self-checking bench for pc_stack
// Queue-based reference model checked every cycle, plus directed literal expectations.
module tb_pc_stack;

    localparam int PS   = 6;
    localparam int SS   = 4;
    localparam int PMOD = 1 << PS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          PCstall = 1'b0, PCincr = 1'b0, PCabsbranch = 1'b0;
    logic          PCrelbranch = 1'b0, PCcall = 1'b0, PCreturn = 1'b0;
    logic [PS-1:0] Branchaddr = '0;
    logic [PS-1:0] PCout;
    logic          StackFull, StackEmpty, StackErr;

    int checks = 0;
    int errors = 0;

    int m_pc = 0;
    int m_stk[$];
    bit m_err = 1'b0;

    pc_stack #(.Psize(PS), .Ssize(SS)) dut (
        .clk(clk), .reset(reset), .PCstall(PCstall), .PCincr(PCincr),
        .PCabsbranch(PCabsbranch), .PCrelbranch(PCrelbranch), .PCcall(PCcall),
        .PCreturn(PCreturn), .Branchaddr(Branchaddr), .PCout(PCout),
        .StackFull(StackFull), .StackEmpty(StackEmpty), .StackErr(StackErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 1'b0;
        end else if (PCstall) begin
            m_pc = m_pc;
        end else if (PCreturn) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (PCcall) begin
            if (m_stk.size() == SS) m_err = 1'b1;
            else begin
                m_stk.push_back((m_pc + 1) % PMOD);
                m_pc = int'(Branchaddr);
            end
        end else if (PCabsbranch) begin
            m_pc = int'(Branchaddr);
        end else if (PCrelbranch) begin
            int off;
            off  = (int'(Branchaddr) >= PMOD / 2) ? int'(Branchaddr) - PMOD : int'(Branchaddr);
            m_pc = (m_pc + off + PMOD) % PMOD;
        end else if (PCincr) begin
            m_pc = (m_pc + 1) % PMOD;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_pc", int'(PCout), m_pc);
            chk("model_full", int'(StackFull), int'(m_stk.size() == SS));
            chk("model_empty", int'(StackEmpty), int'(m_stk.size() == 0));
            chk("model_err", int'(StackErr), int'(m_err));
        end
    end

    // Strobe order: stall, ret, call, abs, rel, incr.
    task automatic step(input logic [5:0] s, input int addr);
        {PCstall, PCreturn, PCcall, PCabsbranch, PCrelbranch, PCincr} = s;
        Branchaddr = PS'(addr);
        @(posedge clk);
        #1;
        {PCstall, PCreturn, PCcall, PCabsbranch, PCrelbranch, PCincr} = '0;
    endtask

    localparam logic [5:0] S_STALL = 6'b100000, S_RET = 6'b010000, S_CALL = 6'b001000;
    localparam logic [5:0] S_ABS = 6'b000100, S_REL = 6'b000010, S_INC = 6'b000001;

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_pc", int'(PCout), 0);
        chk("rst_empty", int'(StackEmpty), 1);
        chk("rst_full", int'(StackFull), 0);
        chk("rst_err", int'(StackErr), 0);
        reset = 1'b0;

        for (int i = 1; i <= 3; i++) begin
            step(S_INC, 0);
            chk("incr_seq", int'(PCout), i);
        end
        step(S_ABS, 63);
        step(S_INC, 0);
        chk("incr_wrap", int'(PCout), 0);

        step(S_ABS, 2);
        step(S_REL, 10);
        chk("rel_pos", int'(PCout), 12);
        step(S_REL, 6'b110000);
        chk("rel_neg16", int'(PCout), 60);
        step(S_ABS, 1);
        step(S_REL, 6'b100000);
        chk("rel_neg32", int'(PCout), 33);

        step(S_ABS, 5);
        step(S_CALL, 40);
        chk("call_pc", int'(PCout), 40);
        chk("call_nonempty", int'(StackEmpty), 0);
        step(S_INC, 0);
        step(S_INC, 0);
        step(S_RET, 0);
        chk("ret_pc", int'(PCout), 6);
        chk("ret_empty", int'(StackEmpty), 1);

        step(S_ABS, 1);
        for (int i = 1; i <= 4; i++) begin
            step(S_CALL, i * 10);
            if (i < 4) step(S_INC, 0);
        end
        chk("nest_full", int'(StackFull), 1);
        chk("nest_noerr", int'(StackErr), 0);
        step(S_CALL, 7);
        chk("over_pc_hold", int'(PCout), 40);
        chk("over_err", int'(StackErr), 1);
        for (int i = 0; i < 4; i++) begin
            step(S_RET, 0);
            chk("nest_ret", int'(PCout), 32 - 10 * i);
        end
        chk("nest_empty", int'(StackEmpty), 1);

        step(S_CALL, 50);
        step(S_STALL | S_CALL | S_INC, 9);
        chk("stall_pc", int'(PCout), 50);
        chk("stall_empty", int'(StackEmpty), 0);
        step(S_RET | S_CALL, 20);
        chk("ret_beats_call", int'(PCout), 3);
        step(S_CALL | S_ABS | S_REL | S_INC, 17);
        chk("call_beats_abs", int'(PCout), 17);
        step(S_ABS | S_REL | S_INC, 25);
        chk("abs_beats_rel", int'(PCout), 25);
        step(S_RET, 0);

        do_reset();
        chk("err_cleared", int'(StackErr), 0);
        step(S_ABS, 9);
        step(S_RET, 0);
        chk("under_pc_hold", int'(PCout), 9);
        chk("under_err", int'(StackErr), 1);
        chk("under_empty", int'(StackEmpty), 1);

        do_reset();
        step(S_CALL, 20);
        step(S_CALL, 30);
        #3;
        reset = 1'b1;
        #1;
        chk("async_pc", int'(PCout), 0);
        chk("async_empty", int'(StackEmpty), 1);
        chk("async_err", int'(StackErr), 0);
        #2;
        reset = 1'b0;
        step(S_INC, 0);
        chk("post_reset_incr", int'(PCout), 1);
        chk("post_reset_empty", int'(StackEmpty), 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
